// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_ctrl
// Brief    : Sequenced 8-bit add/subtract with double-dabble BCD conversion.
//            Optional leading-zero blanking: define CALC_CTRL_ZBLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module calc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       sel,
  input  logic       btn_load,
  output logic       busy,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] sign_code
);

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_CALC   = 3'd2,
    S_CONV   = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  localparam logic [3:0] c_SIGN_MINUS = 4'd10;
  localparam logic [3:0] c_SIGN_PLUS  = 4'd11;
  localparam logic [3:0] c_BLANK      = 4'd15;

  state_t      state_q, state_d;
  logic        btn_q;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        op_q, op_d;
  logic [8:0]  mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d, sign_q, sign_d;

  logic        w_edge;
  logic [11:0] w_bcd_adj;
  logic [11:0] w_bcd_sh;
  logic [8:0]  w_mag_sh;
  logic [3:0]  w_h, w_t, w_o;

  assign w_edge = btn_load & ~btn_q;

  // Add-3 correction on each nibble, then shift magnitude MSB into the scratch.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_nib
      assign w_bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign w_bcd_sh = {w_bcd_adj[10:0], mag_q[8]};
  assign w_mag_sh = {mag_q[7:0], 1'b0};

`ifdef CALC_CTRL_ZBLANK_EN
  assign w_h = (w_bcd_sh[11:8] == 4'd0) ? c_BLANK : w_bcd_sh[11:8];
  assign w_t = (w_bcd_sh[11:4] == 8'd0) ? c_BLANK : w_bcd_sh[7:4];
`else
  assign w_h = w_bcd_sh[11:8];
  assign w_t = w_bcd_sh[7:4];
`endif
  assign w_o = w_bcd_sh[3:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    sign_d  = sign_q;
    case (state_q)
      S_LOAD_A: begin
        if (w_edge) begin
          a_d     = sw;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (w_edge) begin
          b_d     = sw;
          op_d    = sel;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // a < b implies a nonzero difference, so neg never marks a zero.
        if (op_q) begin
          if (a_q >= b_q) begin
            mag_d = {1'b0, a_q - b_q};
            neg_d = 1'b0;
          end else begin
            mag_d = {1'b0, b_q - a_q};
            neg_d = 1'b1;
          end
        end else begin
          mag_d = {1'b0, a_q} + {1'b0, b_q};
          neg_d = 1'b0;
        end
        bcd_d   = 12'd0;
        cnt_d   = 4'd8;
        state_d = S_CONV;
      end
      S_CONV: begin
        bcd_d = w_bcd_sh;
        mag_d = w_mag_sh;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          hund_d  = w_h;
          tens_d  = w_t;
          ones_d  = w_o;
          sign_d  = neg_q ? c_SIGN_MINUS : c_SIGN_PLUS;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (w_edge) begin
          a_d     = sw;
          state_d = S_LOAD_B;
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD_A;
      btn_q   <= 1'b0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      op_q    <= 1'b0;
      mag_q   <= 9'd0;
      neg_q   <= 1'b0;
      bcd_q   <= 12'd0;
      cnt_q   <= 4'd0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      sign_q  <= c_SIGN_PLUS;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_load;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      sign_q  <= sign_d;
    end
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_CONV);
  assign done      = (state_q == S_SHOW);
  assign hund      = hund_q;
  assign tens      = tens_q;
  assign ones      = ones_q;
  assign sign_code = sign_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_ctrl
// Brief    : Directed self-checking bench for calc_ctrl (honours CALC_CTRL_ZBLANK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       sel;
  logic       btn_load;
  logic       busy, done;
  logic [3:0] hund, tens, ones, sign_code;

  int errors = 0;
  int checks = 0;
  int lat;
  int busy_cycles;
  int busy_seen;

`ifdef CALC_CTRL_ZBLANK_EN
  localparam int c_ZB = 1;
`else
  localparam int c_ZB = 0;
`endif

  calc_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .sel       (sel),
    .btn_load  (btn_load),
    .busy      (busy),
    .done      (done),
    .hund      (hund),
    .tens      (tens),
    .ones      (ones),
    .sign_code (sign_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input int h, input int t, input int o, input int s);
    check({tag, "_hund"}, int'(hund), h);
    check({tag, "_tens"}, int'(tens), t);
    check({tag, "_ones"}, int'(ones), o);
    check({tag, "_sign"}, int'(sign_code), s);
  endtask

  // One press: button high across exactly one rising edge, then released.
  task automatic press(input logic [7:0] v, input logic s);
    @(negedge clk);
    sw       = v;
    sel      = s;
    btn_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    btn_load = 1'b0;
    sw       = 8'hA5;
    sel      = ~s;
  endtask

  // Called at the negedge right after the B capture edge (CALC cycle).
  // lat counts edges from the capture edge to the first SHOW sample.
  task automatic finish_op(input bit noise);
    lat         = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      if (busy && done) check("busy_done_excl", 1, 0);
      if (noise) begin
        btn_load = (lat < 8) ? lat[0] : 1'b0;
        sw       = 8'd200;
      end
      @(negedge clk);
      lat++;
    end
    btn_load = 1'b0;
    check("latency", lat, 11);
    check("busy_cycles", busy_cycles, 10);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input bit noise);
    press(a, ~s);
    press(b, s);
    check("busy_calc", int'(busy), 1);
    finish_op(noise);
  endtask

  initial begin
    rst      = 1'b1;
    sw       = 8'd0;
    sel      = 1'b0;
    btn_load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_res("rst", 0, 0, 0, 11);
    rst = 1'b0;

    // 200 + 100 = 300
    run_op(8'd200, 8'd100, 1'b0, 1'b0);
    check("add300_done", int'(done), 1);
    check_res("add300", 3, 0, 0, 11);

    // 255 + 255 = 510, needs mag[8]; previous result held while loading
    press(8'd255, 1'b1);
    check("loadb_done", int'(done), 0);
    check_res("held_loadb", 3, 0, 0, 11);
    press(8'd255, 1'b0);
    repeat (4) @(negedge clk);
    check_res("held_conv", 3, 0, 0, 11);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("add510_done", int'(done), 1);
    check_res("add510", 5, 1, 0, 11);

    // 5 - 20 = -15, with button noise during CALC/CONV
    run_op(8'd5, 8'd20, 1'b1, 1'b1);
    check_res("sub_neg15", c_ZB ? 15 : 0, 1, 5, 10);
    repeat (3) @(negedge clk);
    check("noise_still_show", int'(done), 1);
    check_res("noise_unchanged", c_ZB ? 15 : 0, 1, 5, 10);

    // 77 - 77 = 0, no negative zero
    run_op(8'd77, 8'd77, 1'b1, 1'b0);
    check_res("sub_zero", c_ZB ? 15 : 0, c_ZB ? 15 : 0, 0, 11);

    // Held button in LOAD_A: exactly one capture
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    sw       = 8'd12;
    btn_load = 1'b1;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) busy_seen++;
      sw = 8'd99;
    end
    check("hold_one_capture", busy_seen, 0);
    btn_load = 1'b0;
    @(negedge clk);
    press(8'd30, 1'b0);
    check("hold_busy_calc", int'(busy), 1);
    finish_op(1'b0);
    check_res("hold_add42", c_ZB ? 15 : 0, 4, 2, 11);

    // Reset in the 5th CONV cycle (lat = 6), then a fresh 100 - 23
    press(8'd100, 1'b0);
    press(8'd23, 1'b1);
    repeat (5) @(negedge clk);
    check("midconv_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check_res("midrst", 0, 0, 0, 11);
    rst = 1'b0;
    run_op(8'd100, 8'd23, 1'b1, 1'b0);
    check_res("sub77", c_ZB ? 15 : 0, 7, 7, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the 8-bit add/subtract calculator with BCD seven-segment display.

- Captures operands A and B and the operation select from the switch bank on successive load-button presses.
- Computes the sum or difference and converts the magnitude to three BCD digits with an iterative shift-add-3 (double dabble) engine.
- Holds the digit and sign codes stable for the BCD-to-seven-segment decoders.
- Sits between the board switches/buttons and the four display decoders, replacing the purely combinational adder-to-BCD path with a registered, sequenced one.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- sw  in  8  operand switches, unsigned 0..255
- sel  in  1  operation select: 0 = add, 1 = subtract; sampled with B
- btn_load  in  1  load button, synchronous level; rising edge = one capture
- busy  out  1  high while computing or converting
- done  out  1  high while a valid result is displayed
- hund  out  4  BCD hundreds digit code
- tens  out  4  BCD tens digit code
- ones  out  4  BCD ones digit code
- sign_code  out  4  10 = minus, 11 = plus/blank; feeds the sign digit decoder

## Operation
- Edge detect:
  - btn_q is a register of btn_load.
  - edge = btn_load & ~btn_q.
  - Holding the button produces exactly one edge.
- States:
  - LOAD_A: on edge, a_reg <= sw; go to LOAD_B.
  - LOAD_B: on edge, b_reg <= sw and op_reg <= sel; go to CALC.
  - CALC: one cycle; computes magnitude and sign; edges ignored.
  - CONV: 9 cycles, bit counter 8 down to 0; edges ignored.
  - SHOW: result held; on edge, a_reg <= sw and go to LOAD_B, starting the next calculation.
- Arithmetic in CALC, into a 9-bit magnitude register mag and a neg flag:
  - Add: mag = {1'b0,a_reg} + {1'b0,b_reg}, range 0..510; neg = 0.
  - Subtract: if a_reg >= b_reg, mag = a_reg - b_reg and neg = 0; otherwise mag = b_reg - a_reg and neg = 1. mag[8] = 0.
  - A zero result always has neg = 0.
- Conversion in CONV, per cycle:
  - Any 12-bit BCD scratch nibble >= 5 gets +3.
  - Then {bcd, mag} shifts left by 1.
  - The scratch starts at 0 on entry to CONV.
  - After 9 shifts the scratch holds hundreds/tens/ones.
- Outputs:
  - hund/tens/ones/sign_code are registered.
  - They update only on the CONV->SHOW transition, so the display never shows intermediate values.
  - The previous result stays visible during LOAD_B, CALC and CONV.
- Reset (any state, including mid-CONV):
  - State goes to LOAD_A.
  - a_reg, b_reg, op_reg, mag and scratch clear to 0.
  - hund = tens = ones = 0, sign_code = 11, busy = 0, done = 0.
  - btn_q clears to 0, so a button held through reset gives an edge on the first cycle after reset.

## Timing
- Operand capture edge at cycle k (the rising edge where edge = 1). From the B capture at k:
  - CALC occupies k+1.
  - CONV occupies k+2 .. k+10.
  - SHOW is entered at k+11, with outputs valid and done = 1 from that edge.
- Latency from B capture to valid result: 11 cycles.
- busy = 1 exactly in CALC and CONV (10 cycles).
- done = 1 only in SHOW; it drops on the SHOW->LOAD_B edge.
- busy and done are never both high.
- sw changes while not in LOAD_A, LOAD_B or SHOW have no effect. sel is sampled only on the LOAD_B edge.

## Configuration
- Macro: CALC_CTRL_ZBLANK_EN.
- Defined: leading-zero blanking, applied at the CONV->SHOW update.
  - hund is forced to code 15 (decoder blank) when the hundreds digit is 0.
  - tens is forced to 15 when both hundreds and tens are 0.
  - ones is never blanked.
- Not defined: all three digits always show numeric codes 0..9.

## Test plan
- Reset, then A = 200, B = 100, sel = 0 → after 11 cycles: hund 3, tens 0, ones 0, sign_code 11, done = 1.
- A = 255, B = 255, sel = 0 → 5/1/0, sign_code 11. This exercises mag[8].
- A = 5, B = 20, sel = 1 → 0/1/5, sign_code 10. With CALC_CTRL_ZBLANK_EN: 15/1/5.
- A = 77, B = 77, sel = 1 → 0/0/0, sign_code 11 (no negative zero).
- btn_load held high 20 cycles in LOAD_A → exactly one capture; state remains LOAD_B until a release then a new press. Presses during CALC/CONV are ignored and the result is unchanged.
- rst asserted at the 5th CONV cycle → next cycle: state LOAD_A, all outputs at reset values, busy = 0. A fresh A/B sequence afterwards yields a correct result.
